// File: rtl/picorv32_axi_bridge.sv
// picorv32 native memory interface to AXI4-Lite master bridge.
// Only per-channel acceptance flags are stored; address, data and
// handshake outputs are combinational so a request issues in cycle 0.
module picorv32_axi_bridge (
    input  logic        clk,
    input  logic        reset,

    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,

    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,

    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,

    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,

    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,

    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata
);

    logic ack_aw_q, ack_aw_d;
    logic ack_w_q,  ack_w_d;
    logic ack_ar_q, ack_ar_d;
    logic is_write;
    logic is_read;
    logic xfer_done;

    assign is_write = |mem_wstrb;
    assign is_read  = ~is_write;

    // Address/data channels pass straight through; instruction fetches flag prot[2].
    assign mem_axi_awaddr = mem_addr;
    assign mem_axi_awprot = 3'b000;
    assign mem_axi_wdata  = mem_wdata;
    assign mem_axi_wstrb  = mem_wstrb;
    assign mem_axi_araddr = mem_addr;
    assign mem_axi_arprot = {mem_instr, 2'b00};

    // Each valid is withdrawn once its channel has accepted this request.
    assign mem_axi_awvalid = mem_valid & is_write & ~ack_aw_q;
    assign mem_axi_wvalid  = mem_valid & is_write & ~ack_w_q;
    assign mem_axi_arvalid = mem_valid & is_read  & ~ack_ar_q;
    assign mem_axi_bready  = mem_valid & is_write;
    assign mem_axi_rready  = mem_valid & is_read;

    // Response on either channel completes the native request.
    assign mem_ready = mem_axi_bvalid | mem_axi_rvalid;
    assign mem_rdata = mem_axi_rdata;
    assign xfer_done = mem_valid & mem_ready;

    // Next flag values: completion clears all, otherwise accepted channels latch.
    always_comb begin
        ack_aw_d = ack_aw_q;
        ack_w_d  = ack_w_q;
        ack_ar_d = ack_ar_q;
        if (xfer_done) begin
            ack_aw_d = 1'b0;
            ack_w_d  = 1'b0;
            ack_ar_d = 1'b0;
        end else begin
            if (mem_axi_awvalid && mem_axi_awready) ack_aw_d = 1'b1;
            if (mem_axi_wvalid  && mem_axi_wready)  ack_w_d  = 1'b1;
            if (mem_axi_arvalid && mem_axi_arready) ack_ar_d = 1'b1;
        end
    end

    // Acceptance flag registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_aw_q <= 1'b0;
            ack_w_q  <= 1'b0;
            ack_ar_q <= 1'b0;
        end else begin
            ack_aw_q <= ack_aw_d;
            ack_w_q  <= ack_w_d;
            ack_ar_q <= ack_ar_d;
        end
    end

endmodule

// File: tb/tb_picorv32_axi_bridge.sv
// Self-checking bench for picorv32_axi_bridge: directed protocol scenarios
// followed by a randomized-delay AXI slave with a per-request scoreboard.
module tb_picorv32_axi_bridge;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_err = 0;

    picorv32_axi_bridge dut (
        .clk             (clk),
        .reset           (reset),
        .mem_valid       (mem_valid),
        .mem_instr       (mem_instr),
        .mem_ready       (mem_ready),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_rdata       (mem_rdata),
        .mem_axi_awvalid (awvalid),
        .mem_axi_awready (awready),
        .mem_axi_awaddr  (awaddr),
        .mem_axi_awprot  (awprot),
        .mem_axi_wvalid  (wvalid),
        .mem_axi_wready  (wready),
        .mem_axi_wdata   (wdata),
        .mem_axi_wstrb   (wstrb),
        .mem_axi_bvalid  (bvalid),
        .mem_axi_bready  (bready),
        .mem_axi_arvalid (arvalid),
        .mem_axi_arready (arready),
        .mem_axi_araddr  (araddr),
        .mem_axi_arprot  (arprot),
        .mem_axi_rvalid  (rvalid),
        .mem_axi_rready  (rready),
        .mem_axi_rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_slave();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid  = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    endtask

    // Random-test state
    logic        r_wr, r_instr, r_done;
    logic [31:0] r_addr, r_data, r_rdata;
    logic [3:0]  r_strb;
    int          d_aw, d_w, d_ar, d_resp;
    int          c_aw, c_w, c_ar, wait_cnt;
    logic        resp_ok;

    initial begin
        reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        idle_slave();
        #1;
        // Reset state with idle requester and idle slave
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid",  32'(wvalid),  32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_bready",  32'(bready),  32'd0);
        check("rst_rready",  32'(rready),  32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        tick(); tick();
        reset = 1'b0;

        // Instruction read at 0x100: AR accepted in cycle 0, data in cycle 2
        tick();
        mem_valid = 1'b1; mem_wstrb = 4'h0; mem_addr = 32'h100; mem_instr = 1'b1;
        arready = 1'b1;
        #1;
        check("rd_c0_arvalid", 32'(arvalid), 32'd1);
        check("rd_c0_arprot",  32'(arprot),  32'd4);
        check("rd_c0_araddr",  araddr,       32'h100);
        check("rd_c0_rready",  32'(rready),  32'd1);
        check("rd_c0_awvalid", 32'(awvalid), 32'd0);
        check("rd_c0_mem_ready", 32'(mem_ready), 32'd0);
        tick(); arready = 1'b0; #1;
        check("rd_c1_arvalid", 32'(arvalid), 32'd0);
        check("rd_c1_mem_ready", 32'(mem_ready), 32'd0);
        tick(); rvalid = 1'b1; rdata = 32'hDEADBEEF; #1;
        check("rd_c2_arvalid", 32'(arvalid), 32'd0);
        check("rd_c2_mem_ready", 32'(mem_ready), 32'd1);
        check("rd_c2_mem_rdata", mem_rdata, 32'hDEADBEEF);

        // Write with AW and W accepted together, response in cycle 1
        tick(); idle_slave();
        mem_addr = 32'h1000_0000; mem_wdata = 32'h41; mem_wstrb = 4'b0001; mem_instr = 1'b0;
        awready = 1'b1; wready = 1'b1;
        #1;
        check("wr_c0_awvalid", 32'(awvalid), 32'd1);
        check("wr_c0_wvalid",  32'(wvalid),  32'd1);
        check("wr_c0_awaddr",  awaddr,       32'h1000_0000);
        check("wr_c0_awprot",  32'(awprot),  32'd0);
        check("wr_c0_wdata",   wdata,        32'h41);
        check("wr_c0_wstrb",   32'(wstrb),   32'd1);
        check("wr_c0_bready",  32'(bready),  32'd1);
        check("wr_c0_arvalid", 32'(arvalid), 32'd0);
        check("wr_c0_mem_ready", 32'(mem_ready), 32'd0);
        tick(); idle_slave(); bvalid = 1'b1; #1;
        check("wr_c1_awvalid", 32'(awvalid), 32'd0);
        check("wr_c1_wvalid",  32'(wvalid),  32'd0);
        check("wr_c1_mem_ready", 32'(mem_ready), 32'd1);

        // Back-to-back read at 0x200 issues immediately after write completion
        tick(); idle_slave();
        mem_addr = 32'h200; mem_wstrb = 4'h0; mem_instr = 1'b0;
        #1;
        check("b2b_arvalid", 32'(arvalid), 32'd1);
        check("b2b_arprot",  32'(arprot),  32'd0);
        check("b2b_awvalid", 32'(awvalid), 32'd0);
        check("b2b_bready",  32'(bready),  32'd0);
        tick(); arready = 1'b1; #1;
        check("b2b_arvalid_held", 32'(arvalid), 32'd1);
        tick(); idle_slave(); rvalid = 1'b1; rdata = 32'h1234_5678; #1;
        check("b2b_mem_ready", 32'(mem_ready), 32'd1);
        check("b2b_rdata", mem_rdata, 32'h1234_5678);

        // Write with W accepted in cycle 0 and AW not until cycle 3
        tick(); idle_slave();
        mem_addr = 32'h3000; mem_wdata = 32'hCAFE_0001; mem_wstrb = 4'b1100;
        wready = 1'b1;
        #1;
        check("split_c0_awvalid", 32'(awvalid), 32'd1);
        check("split_c0_wvalid",  32'(wvalid),  32'd1);
        for (int c = 1; c <= 3; c++) begin
            tick(); wready = 1'b1; awready = (c == 3); #1;
            check("split_wvalid_dropped", 32'(wvalid),  32'd0);
            check("split_awvalid_held",   32'(awvalid), 32'd1);
            check("split_no_ready",       32'(mem_ready), 32'd0);
        end
        tick(); idle_slave(); awready = 1'b1; wready = 1'b1; #1;
        check("split_c4_awvalid", 32'(awvalid), 32'd0);
        check("split_c4_wvalid",  32'(wvalid),  32'd0);
        check("split_c4_mem_ready", 32'(mem_ready), 32'd0);
        tick(); idle_slave(); bvalid = 1'b1; #1;
        check("split_c5_mem_ready", 32'(mem_ready), 32'd1);

        // Reset after AW acceptance, before response: valids must reissue
        tick(); idle_slave();
        mem_addr = 32'h4000; mem_wdata = 32'h5555_AAAA; mem_wstrb = 4'hF;
        awready = 1'b1;
        #1;
        check("rstmid_c0_awvalid", 32'(awvalid), 32'd1);
        tick(); idle_slave(); #1;
        check("rstmid_c1_awvalid", 32'(awvalid), 32'd0);
        check("rstmid_c1_wvalid",  32'(wvalid),  32'd1);
        reset = 1'b1; #1;
        check("rstmid_async_awvalid", 32'(awvalid), 32'd1);
        tick(); reset = 1'b0; #1;
        check("rstmid_rel_awvalid", 32'(awvalid), 32'd1);
        check("rstmid_rel_wvalid",  32'(wvalid),  32'd1);
        tick(); awready = 1'b1; wready = 1'b1; #1;
        tick(); idle_slave(); bvalid = 1'b1; #1;
        check("rstmid_done", 32'(mem_ready), 32'd1);
        tick(); idle_slave(); mem_valid = 1'b0; mem_wstrb = 4'h0; #1;
        check("idle_arvalid", 32'(arvalid), 32'd0);
        check("idle_rready",  32'(rready),  32'd0);

        // Randomized slave: every request must see exactly one handshake per channel
        for (int n = 0; n < 1000; n++) begin
            r_wr    = 1'($urandom_range(1, 0));
            r_addr  = $urandom;
            r_data  = $urandom;
            r_rdata = $urandom;
            r_instr = r_wr ? 1'b0 : 1'($urandom_range(1, 0));
            r_strb  = r_wr ? 4'($urandom_range(15, 1)) : 4'h0;
            d_aw = int'($urandom_range(3, 0)); d_w = int'($urandom_range(3, 0));
            d_ar = int'($urandom_range(3, 0)); d_resp = int'($urandom_range(3, 0));
            c_aw = 0; c_w = 0; c_ar = 0; wait_cnt = 0; r_done = 1'b0;

            if ($urandom_range(3, 0) == 0) begin
                tick(); idle_slave(); mem_valid = 1'b0; #1;
                check("gap_awvalid", 32'(awvalid), 32'd0);
                check("gap_arvalid", 32'(arvalid), 32'd0);
            end

            for (int cyc = 0; cyc < 40 && !r_done; cyc++) begin
                tick();
                mem_valid = 1'b1; mem_addr = r_addr; mem_wdata = r_data;
                mem_wstrb = r_strb; mem_instr = r_instr;
                awready = (cyc >= d_aw); wready = (cyc >= d_w); arready = (cyc >= d_ar);
                resp_ok = (r_wr ? (c_aw > 0 && c_w > 0) : (c_ar > 0)) && wait_cnt >= d_resp;
                if (r_wr ? (c_aw > 0 && c_w > 0) : (c_ar > 0)) wait_cnt++;
                bvalid = r_wr & resp_ok;
                rvalid = ~r_wr & resp_ok;
                rdata  = resp_ok ? r_rdata : 32'h0;
                #1;
                if (r_wr) begin
                    check("rnd_wr_arvalid", 32'(arvalid), 32'd0);
                    check("rnd_wr_bready",  32'(bready),  32'd1);
                end else begin
                    check("rnd_rd_awvalid", 32'(awvalid | wvalid), 32'd0);
                    check("rnd_rd_rready",  32'(rready),  32'd1);
                end
                if (awvalid && awready) begin
                    c_aw++;
                    check("rnd_awaddr", awaddr, r_addr);
                    check("rnd_awprot", 32'(awprot), 32'd0);
                end
                if (wvalid && wready) begin
                    c_w++;
                    check("rnd_wdata", wdata, r_data);
                    check("rnd_wstrb", 32'(wstrb), 32'(r_strb));
                end
                if (arvalid && arready) begin
                    c_ar++;
                    check("rnd_araddr", araddr, r_addr);
                    check("rnd_arprot", 32'(arprot), 32'({r_instr, 2'b00}));
                end
                check("rnd_mem_ready", 32'(mem_ready), 32'(resp_ok));
                if (mem_ready) begin
                    r_done = 1'b1;
                    if (!r_wr) check("rnd_rdata", mem_rdata, r_rdata);
                end
            end
            check("rnd_completed", 32'(r_done), 32'd1);
            check("rnd_aw_count", 32'(c_aw), r_wr ? 32'd1 : 32'd0);
            check("rnd_w_count",  32'(c_w),  r_wr ? 32'd1 : 32'd0);
            check("rnd_ar_count", 32'(c_ar), r_wr ? 32'd0 : 32'd1);
        end

        tick(); idle_slave(); mem_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
